// File: rtl/gravity_ctrl.sv
// Gravity timer for a falling-block game: counts seconds-divider edges (or
// clock cycles while soft-drop is held) and raises a one-row drop request.
module gravity_ctrl #(
  parameter int MAX_INT  = 8,
  parameter int SOFT_DIV = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sec_clk,
  input  logic       enable,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       drop_ack,
  output logic       drop_req,
  output logic [7:0] drop_count,
  output logic       busy
);

  localparam int SOFT_W = (SOFT_DIV > 1) ? $clog2(SOFT_DIV) : 1;
  localparam logic [SOFT_W-1:0] SOFT_LAST = SOFT_W'(SOFT_DIV - 1);

  typedef enum logic [1:0] {IDLE, COUNT, SOFT, REQ} state_t;

  state_t            state;
  logic              s_q;
  logic              tick;
  logic [4:0]        interval;
  logic [4:0]        tick_cnt;
  logic [SOFT_W-1:0] soft_cnt;

  // Clamped at 1 so high levels never produce a zero-length interval.
  function automatic logic [4:0] calc_interval(input logic [3:0] lv);
    logic signed [6:0] diff;
    diff = 7'(MAX_INT) - $signed({3'b000, lv});
    if (diff < 7'sd1) return 5'd1;
    return diff[4:0];
  endfunction

  assign tick     = (sec_clk != s_q);
  assign interval = calc_interval(level);

  always_ff @(posedge clock) begin
    s_q <= sec_clk;
    if (!reset) begin
      state      <= IDLE;
      drop_req   <= 1'b0;
      busy       <= 1'b0;
      drop_count <= 8'd0;
      tick_cnt   <= 5'd0;
      soft_cnt   <= '0;
    end else if (!enable) begin
      state    <= IDLE;
      drop_req <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tick_cnt <= 5'd0;
          soft_cnt <= '0;
          busy     <= 1'b1;
          state    <= soft_drop ? SOFT : COUNT;
        end
        COUNT: begin
          // ">=" lets a level raised mid-count fire on the very next tick.
          if (tick && (tick_cnt >= interval - 5'd1)) begin
            tick_cnt <= 5'd0;
            drop_req <= 1'b1;
            state    <= REQ;
          end else if (soft_drop) begin
            soft_cnt <= '0;
            state    <= SOFT;
          end else if (tick) begin
            tick_cnt <= tick_cnt + 5'd1;
          end
        end
        SOFT: begin
          if (!soft_drop) begin
            state <= COUNT;
          end else if (soft_cnt == SOFT_LAST) begin
            soft_cnt <= '0;
            drop_req <= 1'b1;
            state    <= REQ;
          end else begin
            soft_cnt <= soft_cnt + 1'b1;
          end
        end
        REQ: begin
          if (drop_ack) begin
            drop_count <= drop_count + 8'd1;
            tick_cnt   <= 5'd0;
            soft_cnt   <= '0;
            drop_req   <= 1'b0;
            state      <= soft_drop ? SOFT : COUNT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gravity_ctrl.sv
// Randomized and directed bench for gravity_ctrl, checked cycle by cycle
// against a behavioural model of the gravity rules.
module tb_gravity_ctrl;

  localparam int MAX_INT  = 8;
  localparam int SOFT_DIV = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sec_clk = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] level = 4'd0;
  logic       soft_drop = 1'b0;
  logic       drop_ack = 1'b0;
  logic       drop_req;
  logic [7:0] drop_count;
  logic       busy;

  gravity_ctrl #(.MAX_INT(MAX_INT), .SOFT_DIV(SOFT_DIV)) dut (
    .clock(clock), .reset(reset), .sec_clk(sec_clk), .enable(enable),
    .level(level), .soft_drop(soft_drop), .drop_ack(drop_ack),
    .drop_req(drop_req), .drop_count(drop_count), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Behavioural model: running/pending flags plus a tick tally and a soft tally.
  bit running = 0, pending = 0, in_soft = 0;
  int ticks_seen = 0, soft_cycles = 0, drops = 0;
  bit prev_sec = 0;

  task automatic model_update();
    int  iv;
    bit  tk;
    tk = (sec_clk != prev_sec);
    prev_sec = sec_clk;
    iv = MAX_INT - int'(level);
    if (iv < 1) iv = 1;
    if (!reset) begin
      running = 0; pending = 0; in_soft = 0;
      ticks_seen = 0; soft_cycles = 0; drops = 0;
    end else if (!enable) begin
      running = 0; pending = 0;
    end else if (!running) begin
      running = 1; ticks_seen = 0; soft_cycles = 0; in_soft = soft_drop;
    end else if (pending) begin
      if (drop_ack) begin
        drops = (drops + 1) % 256;
        pending = 0; ticks_seen = 0; soft_cycles = 0; in_soft = soft_drop;
      end
    end else if (!in_soft) begin
      if (tk && ticks_seen + 1 >= iv) begin
        pending = 1; ticks_seen = 0;
      end else if (soft_drop) begin
        in_soft = 1; soft_cycles = 0;
      end else if (tk) begin
        ticks_seen++;
      end
    end else begin
      if (!soft_drop) in_soft = 0;
      else if (soft_cycles + 1 == SOFT_DIV) begin
        pending = 1; soft_cycles = 0;
      end else soft_cycles++;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    #1;
    check("drop_req", drop_req, pending);
    check("busy", busy, running);
    check("drop_count", drop_count, drops);
    @(negedge clock);
  endtask

  int ph = 0, edges = 0;

  task automatic gen(input int per);
    if (per > 0) begin
      ph++;
      if (ph >= per) begin
        ph = 0;
        sec_clk = ~sec_clk;
        edges++;
      end
    end
  endtask

  task automatic run(input int n, input int per, input bit auto_ack);
    for (int i = 0; i < n; i++) begin
      gen(per);
      drop_ack = auto_ack ? drop_req : 1'b0;
      step();
    end
    drop_ack = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int budget, input int per);
    int n = 0;
    while (!drop_req && n < budget) begin
      gen(per);
      step();
      n++;
    end
    check(tag, drop_req, 1);
  endtask

  task automatic ack_once();
    drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
  endtask

  initial begin
    int saved, n;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("rst_req", drop_req, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", drop_count, 0);
    reset = 1'b1;

    // Level 5: three edges per drop.
    level = 4'd5; enable = 1'b1; ph = 0; edges = 0;
    wait_req("lvl5_req", 100, 10);
    check("lvl5_edges", edges, 3);
    ack_once();
    check("lvl5_cnt", drop_count, 1);

    // Unacknowledged request: ticks during REQ are discarded.
    wait_req("hold_req", 100, 10);
    run(50, 10, 0);
    check("hold_still", drop_req, 1);
    ack_once();
    edges = 0;
    wait_req("hold_full", 100, 10);
    check("hold_edges", edges, 3);
    ack_once();

    // Interval clamped to 1, then the longest interval.
    level = 4'd12; run(40, 3, 1);
    level = 4'd0;  run(200, 2, 1);

    // Soft drop then release to resume tick counting.
    soft_drop = 1'b1; run(30, 0, 1);
    soft_drop = 1'b0; level = 4'd5; run(80, 4, 1);

    // Pause during REQ with a simultaneous ack.
    wait_req("pause_req", 100, 10);
    saved = drops;
    enable = 1'b0; drop_ack = 1'b1;
    step();
    drop_ack = 1'b0;
    check("pause_req0", drop_req, 0);
    check("pause_busy", busy, 0);
    check("pause_cnt", drop_count, saved);
    enable = 1'b1;

    // Counter wrap 255 -> 0.
    level = 4'd12; n = 0;
    while (drops != 255 && n < 2000) begin run(1, 1, 1); n++; end
    check("wrap_255", drop_count, 255);
    n = 0;
    while (drops != 0 && n < 20) begin run(1, 1, 1); n++; end
    check("wrap_0", drop_count, 0);

    // Reset mid-handshake with sec_clk high, then no spurious tick.
    wait_req("rst_hs_req", 100, 3);
    sec_clk = 1'b1; reset = 1'b0;
    step();
    check("rst_hs_req0", drop_req, 0);
    step();
    reset = 1'b1; level = 4'd12;
    run(10, 0, 0);
    check("no_spurious", drop_req, 0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) != 0);
      enable    = ($urandom_range(0, 99) < 95);
      if ($urandom_range(0, 49) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) soft_drop = ~soft_drop;
      if ($urandom_range(0, 3) == 0) sec_clk = ~sec_clk;
      drop_ack  = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
